// File: rtl/spi_controller.sv
// Write-only SPI mode-0 controller: one 16-bit frame {1'b1, addr[6:0], data[7:0]} per request.
// Optional build macro SPI_CONTROLLER_ADDR_CHECK_EN rejects addresses above 7'h04 with an err pulse.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a request; req_ready high once out of reset
// SHIFT_LO | nCS low, SCLK low, current bit driven on COPI
// SHIFT_HI | nCS low, SCLK high, COPI held for the peripheral to sample
// TRAIL    | nCS low after the last bit, SCLK low
// GAP      | nCS high inter-frame spacing
// DONE     | one-cycle completion pulse
// ERR      | one-cycle rejection pulse (address check builds only)

module spi_controller #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       nCS,
    output logic       SCLK,
    output logic       COPI
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        TRAIL    = 3'd3,
        GAP      = 3'd4,
        DONE     = 3'd5,
        ERR      = 3'd6
    } state_t;

    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LOAD = 8'(CS_GAP - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  div_cnt;
    logic [3:0]  bit_cnt;
    logic [15:0] shift_q;
    logic        ready_en;
    logic        accept;
    logic        div_tc;
    logic        last_bit;
    logic        addr_bad;

    // ready_en keeps req_ready low through reset and sets on the first released edge
    assign accept   = req_valid && ready_en && (state == IDLE);
    assign div_tc   = (div_cnt == 8'd0);
    assign last_bit = (bit_cnt == 4'd0);

`ifdef SPI_CONTROLLER_ADDR_CHECK_EN
    assign addr_bad = (req_addr > 7'h04);
    assign err      = (state == ERR);
`else
    assign addr_bad = 1'b0;
    assign err      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            div_cnt  <= 8'd0;
            bit_cnt  <= 4'd0;
            shift_q  <= 16'd0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            state    <= state_nxt;

            if (state_nxt != state) begin
                div_cnt <= (state_nxt == GAP) ? GAP_LOAD : DIV_LOAD;
            end else if (!div_tc) begin
                div_cnt <= div_cnt - 8'd1;
            end

            // shift only on the HI->LO hand-off so COPI moves while SCLK is low
            if (accept) begin
                shift_q <= {1'b1, req_addr, req_data};
                bit_cnt <= 4'd15;
            end else if (state == SHIFT_HI && div_tc && !last_bit) begin
                shift_q <= {shift_q[14:0], 1'b0};
                bit_cnt <= bit_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        nCS       = 1'b1;
        SCLK      = 1'b0;
        COPI      = 1'b0;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                req_ready = ready_en;
                if (accept) begin
                    state_nxt = addr_bad ? ERR : SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                nCS  = 1'b0;
                COPI = shift_q[15];
                if (div_tc) begin
                    state_nxt = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                nCS  = 1'b0;
                SCLK = 1'b1;
                COPI = shift_q[15];
                if (div_tc) begin
                    state_nxt = last_bit ? TRAIL : SHIFT_LO;
                end
            end
            TRAIL: begin
                nCS  = 1'b0;
                COPI = shift_q[15];
                if (div_tc) begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (div_tc) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            ERR: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
